// File: rtl/branch_resolve_pkg.sv
// Shared constants and types for branch resolution: opcodes, condition codes, flag bit indices.
// No logic; pure definitions.
// Imported by branch_cond and branch_resolve.
package branch_resolve_pkg;

    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SHADOW = 2'd2
    } br_state_e;

    function automatic logic is_branch_op(input logic [3:0] op);
        return (op == OP_B) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/branch_resolve_cond.sv
// Condition evaluator: maps a 3-bit condition code and {N,V,Z} flags to a taken decision.
// Latency: purely combinational.
// Backpressure: none; stateless.
module branch_cond
    import branch_resolve_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] flags,
    output logic       taken
);

    logic z, v, n;
    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    // Decode the condition code against the supplied flags
    always_comb begin
        taken = 1'b0;
        unique case (ccc)
            CC_NE:   taken = !z;
            CC_EQ:   taken = z;
            CC_GT:   taken = !z && !n;
            CC_LT:   taken = n;
            CC_GE:   taken = z || !n;
            CC_LE:   taken = z || n;
            CC_OV:   taken = v;
            CC_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Flag register, B/BR resolution in decode, flag-hazard stall FSM and branch counters.
// Latency: redirect/squash/stall are combinational in the ID cycle; flags visible one edge after EX writes.
// Backpressure: stall_in freezes flags, FSM and counters and masks all control outputs.
// Optional: define BRANCH_FLAG_BYPASS_EN to forward EX flags into decode (removes the hazard stall).
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_in,
    input  logic             ex_valid,
    input  logic [2:0]       ex_flag_d,
    input  logic [2:0]       ex_flag_wen,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [2:0]       id_ccc,
    input  logic [8:0]       id_imm9,
    input  logic [W-1:0]     id_rs_data,
    input  logic [W-1:0]     id_pc_plus2,
    output logic [2:0]       flag,
    output logic             br_taken,
    output logic [W-1:0]     br_target,
    output logic             flush_ifid,
    output logic             id_stall,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e        state_q, state_d;
    logic [2:0]       flag_q, flag_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

    logic             is_br;
    logic             hazard;
    logic [2:0]       eval_flags;
    logic             cond_taken;
    logic             resolve;
    logic             taken_c, flush_c, stall_c;
    logic [W-1:0]     target_b;

    // Bits of the flag register that EX is writing this cycle
    logic [2:0]       ex_wmask;
    assign ex_wmask = {3{ex_valid}} & ex_flag_wen;

    assign is_br = id_valid && is_branch_op(id_opcode);

`ifdef BRANCH_FLAG_BYPASS_EN
    // Forward in-flight EX flags so decode never waits on them
    assign eval_flags = (flag_q & ~ex_wmask) | (ex_flag_d & ex_wmask);
    assign hazard     = 1'b0;
`else
    // Decode sees only committed flags; a conditional branch behind a flag writer must wait
    assign eval_flags = flag_q;
    assign hazard     = (id_ccc != CC_AL) && (|ex_wmask);
`endif

    branch_cond u_cond (
        .ccc   (id_ccc),
        .flags (eval_flags),
        .taken (cond_taken)
    );

    // PC-relative target: word offset scaled to bytes, wraps modulo 2^W
    assign target_b  = id_pc_plus2 + {{(W-10){id_imm9[8]}}, id_imm9, 1'b0};
    assign br_target = (id_opcode == OP_BR) ? id_rs_data : target_b;

    // Resolution FSM next state and combinational control outputs
    always_comb begin
        state_d = state_q;
        resolve = 1'b0;
        taken_c = 1'b0;
        flush_c = 1'b0;
        stall_c = 1'b0;
        if (!stall_in) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (is_br) begin
                        if (hazard) begin
                            stall_c = 1'b1;
                            state_d = ST_WAIT;
                        end else begin
                            resolve = 1'b1;
                            if (cond_taken) begin
                                taken_c = 1'b1;
                                flush_c = 1'b1;
                                state_d = ST_SHADOW;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    // Same ID instruction, flags now committed
                    state_d = ST_IDLE;
                    if (is_br) begin
                        resolve = 1'b1;
                        if (cond_taken) begin
                            taken_c = 1'b1;
                            flush_c = 1'b1;
                            state_d = ST_SHADOW;
                        end
                    end
                end
                ST_SHADOW: begin
                    // Slot behind a taken branch is squashed; ignore whatever ID holds
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held
    assign br_taken   = taken_c && !rst;
    assign flush_ifid = flush_c && !rst;
    assign id_stall   = stall_c && !rst;

    // Flag and counter next-state
    always_comb begin
        flag_d      = flag_q;
        br_cnt_d    = br_cnt_q;
        taken_cnt_d = taken_cnt_q;
        if (!stall_in) begin
            flag_d = (flag_q & ~ex_wmask) | (ex_flag_d & ex_wmask);
            if (resolve) begin
                br_cnt_d = br_cnt_q + CNT_W'(1);
            end
            if (taken_c) begin
                taken_cnt_d = taken_cnt_q + CNT_W'(1);
            end
        end
    end

    // State, flag register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flag_q      <= 3'b000;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flag_q      <= flag_d;
            br_cnt_q    <= br_cnt_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign flag      = flag_q;
    assign br_cnt    = br_cnt_q;
    assign taken_cnt = taken_cnt_q;

endmodule
